// File: rtl/acc_controller.sv
// Accumulator-machine control unit.
// Sequences FETCH / DECODE / EXECUTE over a single memory port, owns the
// program counter and instruction register, and steers the external A
// register (source select, load enable, add/subtract) from the opcode in IR.
// The instruction word carries the opcode in its top three bits and the
// operand address in its low ADDR_W bits.
//
// Input handshake: Enter is a level-sensitive "data ready" strobe. While the
// controller sits in INPUT it ignores Enter=0. In the first cycle Enter=1 it
// loads A from the input port (Asel=01, Aload=1) and leaves INPUT on the
// following edge, so one instruction consumes exactly one Enter-high cycle.
module acc_controller #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] MemData,
   input  logic              Enter,
   input  logic              Aeq0,
   input  logic              Apos,
   output logic [1:0]        Asel,
   output logic              Aload,
   output logic              Sub,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              Mwe,
   output logic [ADDR_W-1:0] PC,
   output logic [DATA_W-1:0] IR,
   output logic              Halt,
   output logic [2:0]        State
);

   // State encodings are exposed on State and must stay fixed.
   typedef enum logic [2:0] {
      ST_START   = 3'b000,
      ST_FETCH   = 3'b001,
      ST_DECODE  = 3'b010,
      ST_EXECUTE = 3'b011,
      ST_INPUT   = 3'b100,
      ST_HALTED  = 3'b101
   } state_t;

   // Opcodes held in IR[DATA_W-1:DATA_W-3].
   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_IN    = 3'b100;
   localparam logic [2:0] OP_JZ    = 3'b101;
   localparam logic [2:0] OP_JPOS  = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   // A register source select codes.
   localparam logic [1:0] ASEL_ALU  = 2'b00;
   localparam logic [1:0] ASEL_IN   = 2'b01;
   localparam logic [1:0] ASEL_MEM  = 2'b10;

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   pc_q;
   logic [DATA_W-1:0]   ir_q;
   logic [2:0]          opcode;
   logic [ADDR_W-1:0]   operand;

   // Datapath register controls produced by the output decoder.
   logic                pc_clr;
   logic                pc_inc;
   logic                pc_jump;
   logic                ir_clr;
   logic                ir_load;

   assign opcode  = ir_q[DATA_W-1:DATA_W-3];
   assign operand = ir_q[ADDR_W-1:0];

   assign PC    = pc_q;
   assign IR    = ir_q;
   assign State = state_q;

   // State register: reset lands in START from any state, aborting whatever
   // instruction was in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_START;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; unused encodings recover through START.
   always_comb begin
      state_d = ST_START;
      case (state_q)
         ST_START:   state_d = ST_FETCH;
         ST_FETCH:   state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_IN:   state_d = ST_INPUT;
               OP_HALT: state_d = ST_HALTED;
               default: state_d = ST_EXECUTE;
            endcase
         end
         ST_EXECUTE: state_d = ST_FETCH;
         ST_INPUT:   state_d = Enter ? ST_FETCH : ST_INPUT;
         ST_HALTED:  state_d = ST_HALTED;
         default:    state_d = ST_START;
      endcase
   end

   // Output decode: A-register steering, memory port and PC/IR controls.
   // Everything idles at zero unless a state/opcode pair below asks for it,
   // which also keeps Aload and Mwe mutually exclusive.
   always_comb begin
      Asel    = ASEL_ALU;
      Aload   = 1'b0;
      Sub     = 1'b0;
      Mwe     = 1'b0;
      Halt    = 1'b0;
      MemAddr = '0;
      pc_clr  = 1'b0;
      pc_inc  = 1'b0;
      pc_jump = 1'b0;
      ir_clr  = 1'b0;
      ir_load = 1'b0;
      case (state_q)
         ST_START: begin
            pc_clr = 1'b1;
            ir_clr = 1'b1;
         end
         ST_FETCH: begin
            MemAddr = pc_q;
            ir_load = 1'b1;
            pc_inc  = 1'b1;
         end
         ST_DECODE: begin
            MemAddr = operand;
         end
         ST_EXECUTE: begin
            MemAddr = operand;
            case (opcode)
               OP_LOAD: begin
                  Asel  = ASEL_MEM;
                  Aload = 1'b1;
               end
               OP_STORE: begin
                  Mwe = 1'b1;
               end
               OP_ADD: begin
                  Asel  = ASEL_ALU;
                  Aload = 1'b1;
               end
               OP_SUB: begin
                  Asel  = ASEL_ALU;
                  Sub   = 1'b1;
                  Aload = 1'b1;
               end
               // Flags are only looked at here, in the EXECUTE cycle.
               OP_JZ:   pc_jump = Aeq0;
               OP_JPOS: pc_jump = Apos;
               default: begin
               end
            endcase
         end
         ST_INPUT: begin
            MemAddr = operand;
            if (Enter) begin
               Asel  = ASEL_IN;
               Aload = 1'b1;
            end
         end
         ST_HALTED: begin
            MemAddr = operand;
            Halt    = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Program counter: clear, increment (wraps naturally at 2^ADDR_W) or jump.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= '0;
      end else if (pc_clr) begin
         pc_q <= '0;
      end else if (pc_inc) begin
         pc_q <= pc_q + ADDR_W'(1);
      end else if (pc_jump) begin
         pc_q <= operand;
      end
   end

   // Instruction register: cleared in START, captured from memory in FETCH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_q <= '0;
      end else if (ir_clr) begin
         ir_q <= '0;
      end else if (ir_load) begin
         ir_q <= MemData;
      end
   end

endmodule

// File: doc/acc_controller.md
ACC_CONTROLLER -- requirements
Module: acc_controller

Interface
REQ-001 SHALL have parameters: ADDR_W, default 5, memory address width; DATA_W, default 8, datapath width (opcode fixed at IR[DATA_W-1:DATA_W-3], operand address at IR[ADDR_W-1:0]).
REQ-002 SHALL have ports:
- clk  input  1  system clock, rising edge; the single clock.
- reset  input  1  asynchronous, active-low reset.
- MemData  input  DATA_W  memory read data, combinational from MemAddr.
- Enter  input  1  external input-ready strobe, level.
- Aeq0  input  1  accumulator-equals-zero flag from A register.
- Apos  input  1  accumulator-positive flag (MSB=0, nonzero) from A register.
- Asel  output  2  A register source select: 00 add/sub result, 01 Input port, 10 MemData, 11 zero.
- Aload  output  1  A register load enable.
- Sub  output  1  1 = subtract, 0 = add, to add/sub unit.
- MemAddr  output  ADDR_W  memory address.
- Mwe  output  1  memory write enable (write A to MemAddr on clk edge).
- PC  output  ADDR_W  program counter.
- IR  output  DATA_W  instruction register.
- Halt  output  1  high while halted.
- State  output  3  current FSM state encoding.

Function
REQ-003 SHALL implement Moore/Mealy FSM with states START=000, FETCH=001, DECODE=010, EXECUTE=011, INPUT=100, HALTED=101; codes 110/111 SHALL go to START.
REQ-004 START SHALL clear PC and IR, then go to FETCH next cycle.
REQ-005 FETCH SHALL drive MemAddr=PC; on the edge IR<=MemData, PC<=PC+1 (wraps 31->0); next state DECODE.
REQ-006 DECODE SHALL drive MemAddr=IR[4:0], assert no load/write; next state EXECUTE, except IN->INPUT and HALT->HALTED.
REQ-007 EXECUTE SHALL drive MemAddr=IR[4:0] and, per opcode, for exactly one cycle:
- 000 LOAD: Asel=10, Aload=1.
- 001 STORE: Mwe=1.
- 010 ADD: Asel=00, Sub=0, Aload=1.
- 011 SUB: Asel=00, Sub=1, Aload=1.
- 101 JZ: if Aeq0 then PC<=IR[4:0].
- 110 JPOS: if Apos then PC<=IR[4:0].
then next state FETCH.
REQ-008 Aeq0/Apos SHALL be sampled in the EXECUTE cycle only; not-taken jump leaves PC unchanged.
REQ-009 INPUT (opcode 100) SHALL hold Aload=0 while Enter=0; in the cycle Enter=1 SHALL assert Asel=01, Aload=1 and go to FETCH.
REQ-010 HALTED (opcode 111) SHALL assert Halt=1, hold PC/IR, assert no Aload/Mwe; only reset exits.
REQ-011 Outside the listed cases Aload=0, Mwe=0, Sub=0, Asel=00; Aload and Mwe SHALL never both be 1.
REQ-012 Latency: non-input instruction SHALL take exactly 3 cycles (FETCH, DECODE, EXECUTE).
REQ-013 PC+1 wrap and jump target SHALL both be modulo 2^ADDR_W.

Reset
REQ-014 reset=0 SHALL immediately (asynchronously) force State=START, PC=0, IR=0, Halt=0, Aload=0, Mwe=0, Sub=0, Asel=00, MemAddr=0.
REQ-015 Reset asserted mid-instruction (any state, incl. INPUT/HALTED) SHALL abort it with no Aload/Mwe pulse; after release, first FETCH occurs on second rising edge (START, then FETCH).

Verification
REQ-016 Reset then memory {0:LOAD 10, 1:ADD 11, 2:STORE 12, 3:HALT}, M[10]=3, M[11]=4 -> Aload pulses with Asel=10 then 00/Sub=0, Mwe pulse at MemAddr=12, Halt=1 after 12 cycles, PC=4.
REQ-017 JZ 7 at PC=0 with Aeq0=1 in EXECUTE -> next FETCH MemAddr=7; repeat with Aeq0=0 -> MemAddr=1.
REQ-018 IN with Enter held 0 for 5 cycles then 1 -> State=100 for 6 cycles, single Aload with Asel=01 on Enter cycle, then FETCH.
REQ-019 PC=31 fetching LOAD 0 -> PC wraps to 0 after FETCH.
REQ-020 reset=0 asserted asynchronously during EXECUTE of STORE -> Mwe drops immediately, State=000, PC=0 without clock edge.
REQ-021 SUB 5 with M[5]=1 -> Asel=00, Sub=1, Aload=1 in exactly one EXECUTE cycle.
